debounce_scheduler: RTL and testbench
=====================================

# debounce_scheduler

Debounces N push-button inputs using a single shared hold-off counter instead of one timer per button. A round-robin scheduler grants the counter to one channel at a time, namely a channel whose synchronized raw level differs from its debounced level. The block emits stable levels plus one-cycle press/release pulses. It sits between the board button pins and the lab control FSMs that consume clean button events.

## Interface
- `N`, default 4: number of button channels, 1..8.
- `HOLD`, default 1_000_000: stable cycles required before a change is accepted; at 50 MHz this is 20 ms; minimum 2.
- `CNT_W`, default 20: counter width; must satisfy 2^CNT_W ≥ HOLD.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in` in N: raw, asynchronous button levels; 1 = pressed.
- `out` out N: debounced levels.
- `press` out N: one-cycle pulse when `out[i]` rises.
- `release` out N: one-cycle pulse when `out[i]` falls.
- `grant` out N: one-hot, the channel currently owning the counter; 0 when idle.
- `busy` out 1: high when the scheduler is not in IDLE.

## Operation
- **Synchronizer.** A 2-flop synchronizer per bit produces `in_s`. Channel i is pending when `in_s[i] != out[i]`.
- **IDLE.**
  - If any channel is pending, pick the first pending index at or after `ptr`, searching with wrap-around.
  - Set `grant` to that one-hot, clear `cnt` to 0, and go to TIMING.
  - If no channel is pending, stay in IDLE.
- **TIMING.** Let g be the granted channel.
  - If `in_s[g] == out[g]` (bounce back): abort, set `ptr` = g+1 mod N, clear `grant`, go to IDLE. `out` is unchanged and no pulse is issued.
  - Else if `cnt == HOLD-1`: go to COMMIT.
  - Else `cnt` increments by 1.
- **COMMIT.**
  - `out[g]` toggles.
  - Pulse `press[g]` if the new value is 1, otherwise pulse `release[g]`. The pulse is asserted in the cycle after COMMIT, coincident with the new `out`.
  - Set `ptr` = g+1 mod N, clear `grant`, go to IDLE.
- **Non-granted channels** never change `out`. Their pending state is simply re-evaluated when the scheduler next enters IDLE.
- **Counter width.** `cnt` is CNT_W bits and never wraps, because it stops at HOLD-1.
- **Reset (asserted at any time, including mid-TIMING or mid-COMMIT).** Immediately sets:
  - `out`, `press`, `release`, `grant` = 0
  - `busy` = 0
  - state = IDLE, `ptr` = 0, `cnt` = 0
  - synchronizer flops = 0

  A button held through reset is seen as pending once reset is released, and is debounced normally.

## Timing
- **Latency.** Let edge 0 be the first rising edge that samples a new stable level while the scheduler is idle.
  - Edge 2: TIMING is entered.
  - Edge HOLD+2: COMMIT is entered.
  - Edge HOLD+3: `out` and the pulse update. Total latency is HOLD+3 edges.
- **Simultaneous changes on k channels.** Channels are served sequentially in round-robin order from `ptr`. Each channel costs HOLD+2 cycles after the previous one finishes. Between consecutive grants there is exactly one IDLE cycle.
- **Bounce during TIMING.** A mismatch that disappears before `cnt` reaches HOLD-1 causes an abort. A new change restarts from `cnt` = 0 when the channel is next granted.
- **Re-toggle during COMMIT.** A level change arriving during COMMIT is treated as a new pending event after IDLE.
- **Pulse shape.** `press` and `release` are never both high for the same channel, and each pulse lasts exactly one cycle.
- **Output registration.** All outputs are registered. There are no combinational paths from `in` to any output.

## Structure
- **Package `debounce_pkg`:**
  - State encoding: IDLE=2'b00, TIMING=2'b01, COMMIT=2'b10. The value 2'b11 is unreachable and recovers to IDLE.
  - Default HOLD/CNT_W constants for the 50 MHz board clock.
- **Sub-module `rr_pick`:** purely combinational. Takes the N-bit pending mask and `ptr`, and returns a one-hot grant plus a valid flag. It is instantiated once.
- **Top-level contents:** synchronizer, FSM, counter, `out` register and pulse registers.

## Test plan
All scenarios use N=4, HOLD=4.
- **Clean press.** `in`=4'b0001, held steady → `out[0]` rises 7 edges later. `press[0]` is high for one cycle in the same cycle. `grant` goes 0001 during TIMING/COMMIT, then 0000.
- **Bounce abort.** `in[1]` high for 3 cycles, then low → no change on `out`, `press` stays 0. `grant` returns to 0 and `busy` drops. `ptr` advances to 2: a subsequent simultaneous press on ch0 and ch3 is served ch3 first.
- **Simultaneous arrival.** `in`=4'b1010 in one cycle after reset → `out[1]` rises 7 edges later, `out[3]` rises HOLD+2=6 edges after that. Pulses appear in that order.
- **Release.** With `out[2]`=1, drop `in[2]` → `release[2]` pulse, and `out[2]` falls 7 edges after the sampling edge.
- **Async reset mid-TIMING.** Pull `reset_n` low between clock edges while `grant`=0100 → all outputs go 0 without waiting for a clock edge. After release with `in[2]` still high, `out[2]` rises 7 edges after the first sampling edge.
- **Round-robin fairness.** Toggle ch0 and ch1 continuously at intervals of at least 7 cycles → grants alternate between the two channels and neither starves. Each commit produces exactly one pulse.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared encodings and board defaults for the round-robin button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_TIMING = 2'b01,
        ST_COMMIT = 2'b10,
        ST_BAD    = 2'b11
    } state_e;

    // 20 ms hold-off at the 50 MHz board clock.
    localparam int DEF_HOLD  = 1_000_000;
    localparam int DEF_CNT_W = 20;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_scheduler_rr_pick.sv
// Combinational round-robin picker: first pending channel at or after ptr, with wrap.
module rr_pick
    import debounce_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  pend,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  oh,
    output logic          valid
);

    logic found;

    always_comb begin
        oh    = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && pend[(int'(ptr) + k) % N]) begin
                oh[(int'(ptr) + k) % N] = 1'b1;
                found = 1'b1;
            end
        end
        valid = |pend;
    end

endmodule

// File: rtl/debounce_scheduler.sv
// N-channel button debouncer sharing one hold-off counter among channels via a
// round-robin scheduler; emits stable levels and one-cycle press/release pulses.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int N     = 4,
    parameter int HOLD  = DEF_HOLD,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] in,
    output logic [N-1:0] out,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] grant,
    output logic         busy
);

    localparam int PW = ptr_width(N);
    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);

    state_e            state_q, state_d;
    logic [N-1:0]      sync1_q, sync1_d;
    logic [N-1:0]      sync2_q, sync2_d;
    logic [N-1:0]      out_q, out_d;
    logic [N-1:0]      press_q, press_d;
    logic [N-1:0]      rel_q, rel_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N-1:0]      pend;
    logic [N-1:0]      pick_oh;
    logic              pick_valid;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     next_ptr;

    assign pend = sync2_q ^ out_q;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .pend  (pend),
        .ptr   (ptr_q),
        .oh    (pick_oh),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_oh[i]) pick_idx = PW'(i);
        end
    end

    assign next_ptr = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + PW'(1);

    always_comb begin
        sync1_d = in;
        sync2_d = sync1_q;
        state_d = state_q;
        out_d   = out_q;
        press_d = '0;
        rel_d   = '0;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_TIMING;
                end
            end
            ST_TIMING: begin
                // Raw level fell back to the debounced value: drop the grant, no event.
                if (sync2_q[gidx_q] == out_q[gidx_q]) begin
                    ptr_d   = next_ptr;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == HOLD_M1) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                out_d[gidx_q] = ~out_q[gidx_q];
                if (!out_q[gidx_q]) begin
                    press_d[gidx_q] = 1'b1;
                end else begin
                    rel_d[gidx_q] = 1'b1;
                end
                ptr_d   = next_ptr;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            out_q   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            out_q   <= out_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out           = out_q;
    assign press         = press_q;
    assign release_pulse = rel_q;
    assign grant         = grant_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with N=4, HOLD=4 (latency HOLD+3 = 7 edges).
module tb_debounce_scheduler;

    localparam int N     = 4;
    localparam int HOLD  = 4;
    localparam int CNT_W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] in_r = '0;
    logic [N-1:0] out, press, rel, grant;
    logic         busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    debounce_scheduler #(.N(N), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in            (in_r),
        .out           (out),
        .press         (press),
        .release_pulse (rel),
        .grant         (grant),
        .busy          (busy)
    );

    // Pulse-shape monitor and grant history, sampled on the falling edge.
    int           viol = 0;
    int           press_cnt[N];
    int           rel_cnt[N];
    logic [N-1:0] press_prev = '0;
    logic [N-1:0] rel_prev = '0;
    logic [N-1:0] grant_prev = '0;
    logic [N-1:0] got_q[$];

    initial begin
        for (int i = 0; i < N; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if ((press & rel) != '0) viol++;
            if ((press & press_prev) != '0 || (rel & rel_prev) != '0) viol++;
            for (int i = 0; i < N; i++) begin
                if (press[i]) press_cnt[i]++;
                if (rel[i]) rel_cnt[i]++;
            end
            if (grant != grant_prev && grant != '0) got_q.push_back(grant);
        end
        press_prev = press;
        rel_prev = rel;
        grant_prev = grant;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_r = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        in_r = 4'b1111;
        reset_n = 1'b0;
        repeat (3) step();
        checks++; if (out !== 4'b0) begin failures++; $display("FAIL reset_out got=%b exp=0000", out); end
        checks++; if (press !== 4'b0 || rel !== 4'b0) begin failures++; $display("FAIL reset_pulse got=%b/%b exp=0000/0000", press, rel); end
        checks++; if (grant !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_grant got=%b busy=%b exp=0000 busy=0", grant, busy); end
        in_r = '0;
    endtask

    task automatic test_clean_press();
        do_reset();
        @(negedge clk);
        in_r = 4'b0001;
        for (int e = 0; e <= 8; e++) begin
            step();
            if (e == 1) begin
                checks++; if (busy !== 1'b0 || grant !== 4'b0) begin failures++; $display("FAIL press_e1 grant=%b busy=%b exp=0000 0", grant, busy); end
            end
            if (e >= 2 && e <= 6) begin
                checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL press_grant e=%0d grant=%b busy=%b exp=0001 1", e, grant, busy); end
            end
            if (e <= 6) begin
                checks++; if (out !== 4'b0 || press !== 4'b0) begin failures++; $display("FAIL press_early e=%0d out=%b press=%b exp=0000", e, out, press); end
            end
            if (e == 7) begin
                checks++; if (out !== 4'b0001 || press !== 4'b0001 || rel !== 4'b0) begin failures++; $display("FAIL press_commit out=%b press=%b rel=%b exp=0001 0001 0000", out, press, rel); end
                checks++; if (grant !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL press_idle grant=%b busy=%b exp=0000 0", grant, busy); end
            end
            if (e == 8) begin
                checks++; if (out !== 4'b0001 || press !== 4'b0) begin failures++; $display("FAIL press_after out=%b press=%b exp=0001 0000", out, press); end
            end
        end
    endtask

    task automatic test_release();
        do_reset();
        @(negedge clk);
        in_r = 4'b0100;
        repeat (9) step();
        checks++; if (out !== 4'b0100) begin failures++; $display("FAIL rel_setup out=%b exp=0100", out); end
        @(negedge clk);
        in_r = 4'b0000;
        for (int e = 0; e <= 8; e++) begin
            step();
            if (e == 6) begin
                checks++; if (out !== 4'b0100 || rel !== 4'b0) begin failures++; $display("FAIL rel_early out=%b rel=%b exp=0100 0000", out, rel); end
            end
            if (e == 7) begin
                checks++; if (out !== 4'b0000 || rel !== 4'b0100 || press !== 4'b0) begin failures++; $display("FAIL rel_commit out=%b rel=%b press=%b exp=0000 0100 0000", out, rel, press); end
            end
            if (e == 8) begin
                checks++; if (rel !== 4'b0) begin failures++; $display("FAIL rel_after rel=%b exp=0000", rel); end
            end
        end
    endtask

    task automatic test_bounce();
        int p0;
        do_reset();
        p0 = press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3];
        @(negedge clk);
        in_r = 4'b0010;
        repeat (3) step();
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL bounce_grant got=%b exp=0010", grant); end
        @(negedge clk);
        in_r = 4'b0000;
        repeat (4) step();
        checks++; if (grant !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL bounce_abort grant=%b busy=%b exp=0000 0", grant, busy); end
        checks++; if (out !== 4'b0) begin failures++; $display("FAIL bounce_out got=%b exp=0000", out); end
        checks++; if (press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] != p0) begin failures++; $display("FAIL bounce_pulse got=%0d exp=%0d", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], p0); end
        // ptr now sits at 2, so channel 3 is served before channel 0.
        @(negedge clk);
        in_r = 4'b1001;
        for (int e = 0; e <= 13; e++) begin
            step();
            if (e == 2) begin
                checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL bounce_rr_grant got=%b exp=1000", grant); end
            end
            if (e == 7) begin
                checks++; if (out !== 4'b1000 || press !== 4'b1000) begin failures++; $display("FAIL bounce_rr_first out=%b press=%b exp=1000 1000", out, press); end
            end
            if (e == 13) begin
                checks++; if (out !== 4'b1001 || press !== 4'b0001) begin failures++; $display("FAIL bounce_rr_second out=%b press=%b exp=1001 0001", out, press); end
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(negedge clk);
        in_r = 4'b1010;
        for (int e = 0; e <= 13; e++) begin
            step();
            if (e == 7) begin
                checks++; if (out !== 4'b0010 || press !== 4'b0010) begin failures++; $display("FAIL simul_first out=%b press=%b exp=0010 0010", out, press); end
            end
            if (e == 8) begin
                checks++; if (grant !== 4'b1000 || busy !== 1'b1) begin failures++; $display("FAIL simul_regrant grant=%b busy=%b exp=1000 1", grant, busy); end
            end
            if (e == 12) begin
                checks++; if (out !== 4'b0010) begin failures++; $display("FAIL simul_early out=%b exp=0010", out); end
            end
            if (e == 13) begin
                checks++; if (out !== 4'b1010 || press !== 4'b1000) begin failures++; $display("FAIL simul_second out=%b press=%b exp=1010 1000", out, press); end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        in_r = 4'b0100;
        repeat (4) step();
        checks++; if (grant !== 4'b0100 || busy !== 1'b1) begin failures++; $display("FAIL areset_pre grant=%b busy=%b exp=0100 1", grant, busy); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0 || busy !== 1'b0 || out !== 4'b0 || press !== 4'b0) begin failures++; $display("FAIL areset_now grant=%b busy=%b out=%b press=%b exp=0000 0 0000 0000", grant, busy, out, press); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            step();
            if (e == 6) begin
                checks++; if (out !== 4'b0) begin failures++; $display("FAIL areset_early out=%b exp=0000", out); end
            end
            if (e == 7) begin
                checks++; if (out !== 4'b0100 || press !== 4'b0100) begin failures++; $display("FAIL areset_commit out=%b press=%b exp=0100 0100", out, press); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_q[$];
        int sz0;
        int pc0, pc1, rc0, rc1;
        do_reset();
        sz0 = got_q.size();
        pc0 = press_cnt[0]; pc1 = press_cnt[1];
        rc0 = rel_cnt[0];   rc1 = rel_cnt[1];
        for (int it = 0; it < 4; it++) begin
            @(negedge clk);
            in_r[1:0] = ~in_r[1:0];
            exp_q.push_back(4'b0001);
            exp_q.push_back(4'b0010);
            repeat (15) step();
            checks++; if (out !== in_r) begin failures++; $display("FAIL rr_level it=%0d out=%b exp=%b", it, out, in_r); end
        end
        checks++; if (got_q.size() - sz0 != exp_q.size()) begin failures++; $display("FAIL rr_grant_count got=%0d exp=%0d", got_q.size() - sz0, exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[sz0 + i] !== exp_q[i]) begin failures++; $display("FAIL rr_grant_order i=%0d got=%b exp=%b", i, got_q[sz0 + i], exp_q[i]); end
            end
        end
        checks++; if (press_cnt[0] - pc0 != 2 || press_cnt[1] - pc1 != 2) begin failures++; $display("FAIL rr_press_cnt got=%0d,%0d exp=2,2", press_cnt[0] - pc0, press_cnt[1] - pc1); end
        checks++; if (rel_cnt[0] - rc0 != 2 || rel_cnt[1] - rc1 != 2) begin failures++; $display("FAIL rr_rel_cnt got=%0d,%0d exp=2,2", rel_cnt[0] - rc0, rel_cnt[1] - rc1); end
        checks++; if (viol != 0) begin failures++; $display("FAIL pulse_shape violations=%0d exp=0", viol); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_async_reset();
        test_round_robin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
